// File: rtl/delay_timer_p_if.sv
// Control/status bundle for delay_timer_p: start/abort/mode requests in, busy/expiry/count out.
// WIDTH must match the WIDTH of the timer instance it connects to.
interface delay_timer_p_if #(
  parameter int WIDTH = 16
);
  logic             trigger;
  logic             cancel;
  logic             periodic;
  logic [WIDTH-1:0] N;
  logic             busy;
  logic             time_out;
  logic [WIDTH-1:0] remaining;

  modport master (
    output trigger, cancel, periodic, N,
    input  busy, time_out, remaining
  );

  modport slave (
    input  trigger, cancel, periodic, N,
    output busy, time_out, remaining
  );
endinterface

// File: rtl/delay_timer_p.sv
// Programmable one-shot / auto-reload delay timer with clock prescaler and cancel.
// Optional macro DELAY_TIMER_RETRIGGER_EN: trigger while running restarts the run.
module delay_timer_p #(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  delay_timer_p_if.slave bus
);
  localparam int             PW      = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] period;
  logic             mode;
  logic [WIDTH-1:0] remaining;
  logic [PW-1:0]    prescaler;
  logic             time_out;
  logic             tick;
  logic             start_ok;

  assign tick      = (prescaler == PS_LAST);
  assign start_ok  = bus.trigger && !bus.cancel && (bus.N != '0);

  assign bus.busy      = (state == RUN);
  assign bus.time_out  = time_out;
  assign bus.remaining = remaining;

  // NOTE: all state below uses non-blocking assignment so every register sees
  // pre-edge values; later assignments in the block intentionally override earlier ones.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      period    <= '0;
      mode      <= 1'b0;
      remaining <= '0;
      prescaler <= '0;
      time_out  <= 1'b0;
    end else begin
      time_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            period    <= bus.N;
            mode      <= bus.periodic;
            remaining <= bus.N;
            prescaler <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (bus.cancel) begin
            state     <= IDLE;
            remaining <= '0;
            prescaler <= '0;
          end else begin
            prescaler <= tick ? '0 : prescaler + PW'(1);
            if (tick) begin
              if (remaining == WIDTH'(1)) begin
                time_out <= 1'b1;
                if (mode) begin
                  remaining <= period;
                end else begin
                  remaining <= '0;
                  state     <= IDLE;
                end
              end else begin
                remaining <= remaining - WIDTH'(1);
              end
            end
`ifdef DELAY_TIMER_RETRIGGER_EN
            // A restart overrides both the one-shot return to IDLE and the periodic reload.
            if (bus.trigger && (bus.N != '0)) begin
              period    <= bus.N;
              mode      <= bus.periodic;
              remaining <= bus.N;
              prescaler <= '0;
              state     <= RUN;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_delay_timer_p.sv
// Directed self-checking bench for delay_timer_p: three instances cover
// PRESCALE=1, PRESCALE=4 and WIDTH=8.
module tb_delay_timer_p;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  delay_timer_p_if #(.WIDTH(16)) if_a ();
  delay_timer_p_if #(.WIDTH(16)) if_b ();
  delay_timer_p_if #(.WIDTH(8))  if_c ();

  delay_timer_p #(.WIDTH(16), .PRESCALE(1)) u_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
  delay_timer_p #(.WIDTH(16), .PRESCALE(4)) u_b (.clk(clk), .reset_n(reset_n), .bus(if_b));
  delay_timer_p #(.WIDTH(8),  .PRESCALE(1)) u_c (.clk(clk), .reset_n(reset_n), .bus(if_c));

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pulse(input int sel);
    case (sel)
      0:       return if_a.time_out;
      1:       return if_b.time_out;
      default: return if_c.time_out;
    endcase
  endfunction

  // Step 'cycles' edges; c=1 is the first edge after the call.
  task automatic watch(input int sel, input int cycles, output int first, output int count, output int last);
    first = -1; count = 0; last = -1;
    for (int c = 1; c <= cycles; c++) begin
      step();
      if (pulse(sel)) begin
        if (first < 0) first = c;
        last = c;
        count++;
      end
    end
  endtask

  task automatic test_reset();
    int first, count, last;
    reset_n = 1'b0;
    step(); step();
    checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", if_a.busy); end
    checks++; if (if_a.time_out !== 1'b0) begin errors++; $display("FAIL reset_time_out: got %0b want 0", if_a.time_out); end
    checks++; if (if_a.remaining !== 16'd0) begin errors++; $display("FAIL reset_remaining: got %0d want 0", if_a.remaining); end
    reset_n = 1'b1;
    if_a.N = 16'd10; if_a.trigger = 1'b1;
    step();
    if_a.trigger = 1'b0;
    step(); step(); step();
    reset_n = 1'b0;
    step(); step();
    checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL midrun_reset_busy: got %0b want 0", if_a.busy); end
    checks++; if (if_a.remaining !== 16'd0) begin errors++; $display("FAIL midrun_reset_remaining: got %0d want 0", if_a.remaining); end
    reset_n = 1'b1;
    watch(0, 15, first, count, last);
    checks++; if (count !== 0) begin errors++; $display("FAIL midrun_reset_no_pulse: got %0d pulses want 0", count); end
    if_a.N = 16'd3; if_a.trigger = 1'b1;
    step();
    if_a.trigger = 1'b0;
    watch(0, 8, first, count, last);
    checks++; if (first !== 3 || count !== 1) begin errors++; $display("FAIL post_reset_run: got first=%0d count=%0d want first=3 count=1", first, count); end
  endtask

  task automatic test_oneshot();
    if_a.N = 16'd5; if_a.periodic = 1'b0; if_a.trigger = 1'b1;
    step();
    if_a.trigger = 1'b0;
    checks++; if (if_a.busy !== 1'b1 || if_a.remaining !== 16'd5) begin errors++; $display("FAIL oneshot_start: got busy=%0b rem=%0d want busy=1 rem=5", if_a.busy, if_a.remaining); end
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (if_a.busy !== 1'b1 || if_a.remaining !== 16'(5 - i) || if_a.time_out !== 1'b0) begin
        errors++; $display("FAIL oneshot_count_%0d: got busy=%0b rem=%0d to=%0b want busy=1 rem=%0d to=0", i, if_a.busy, if_a.remaining, if_a.time_out, 5 - i);
      end
    end
    step();
    checks++; if (if_a.time_out !== 1'b1 || if_a.busy !== 1'b0 || if_a.remaining !== 16'd0) begin errors++; $display("FAIL oneshot_expiry: got to=%0b busy=%0b rem=%0d want to=1 busy=0 rem=0", if_a.time_out, if_a.busy, if_a.remaining); end
    step();
    checks++; if (if_a.time_out !== 1'b0) begin errors++; $display("FAIL oneshot_pulse_width: got %0b want 0", if_a.time_out); end
  endtask

  task automatic test_periodic();
    int first, count, last;
    if_b.N = 16'd3; if_b.periodic = 1'b1; if_b.trigger = 1'b1;
    step();
    if_b.trigger = 1'b0; if_b.periodic = 1'b0; if_b.N = 16'd7;
    checks++; if (if_b.busy !== 1'b1 || if_b.remaining !== 16'd3) begin errors++; $display("FAIL periodic_start: got busy=%0b rem=%0d want busy=1 rem=3", if_b.busy, if_b.remaining); end
    watch(1, 36, first, count, last);
    checks++; if (first !== 12 || count !== 3 || last !== 36) begin errors++; $display("FAIL periodic_pulses: got first=%0d count=%0d last=%0d want 12 3 36", first, count, last); end
    checks++; if (if_b.busy !== 1'b1 || if_b.remaining !== 16'd3) begin errors++; $display("FAIL periodic_reload: got busy=%0b rem=%0d want busy=1 rem=3", if_b.busy, if_b.remaining); end
    if_b.cancel = 1'b1;
    step();
    if_b.cancel = 1'b0;
    checks++; if (if_b.busy !== 1'b0 || if_b.remaining !== 16'd0) begin errors++; $display("FAIL periodic_cancel: got busy=%0b rem=%0d want busy=0 rem=0", if_b.busy, if_b.remaining); end
    watch(1, 30, first, count, last);
    checks++; if (count !== 0) begin errors++; $display("FAIL periodic_after_cancel: got %0d pulses want 0", count); end
  endtask

  task automatic test_boundaries();
    int first, count, last;
    if_a.N = 16'd0; if_a.trigger = 1'b1;
    step();
    if_a.trigger = 1'b0;
    checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL n0_busy: got %0b want 0", if_a.busy); end
    watch(0, 5, first, count, last);
    checks++; if (count !== 0) begin errors++; $display("FAIL n0_pulse: got %0d pulses want 0", count); end
    if_a.N = 16'd1; if_a.trigger = 1'b1;
    step();
    if_a.trigger = 1'b0;
    checks++; if (if_a.busy !== 1'b1 || if_a.remaining !== 16'd1) begin errors++; $display("FAIL n1_start: got busy=%0b rem=%0d want busy=1 rem=1", if_a.busy, if_a.remaining); end
    watch(0, 4, first, count, last);
    checks++; if (first !== 1 || count !== 1) begin errors++; $display("FAIL n1_pulse: got first=%0d count=%0d want 1 1", first, count); end
    if_c.N = 8'd255; if_c.periodic = 1'b0; if_c.trigger = 1'b1;
    step();
    if_c.trigger = 1'b0;
    checks++; if (if_c.remaining !== 8'd255) begin errors++; $display("FAIL w8_start: got rem=%0d want 255", if_c.remaining); end
    watch(2, 260, first, count, last);
    checks++; if (first !== 255 || count !== 1 || if_c.busy !== 1'b0) begin errors++; $display("FAIL w8_max: got first=%0d count=%0d busy=%0b want 255 1 0", first, count, if_c.busy); end
    if_a.N = 16'd4; if_a.trigger = 1'b1; if_a.cancel = 1'b1;
    step();
    if_a.trigger = 1'b0; if_a.cancel = 1'b0;
    checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL trig_cancel_busy: got %0b want 0", if_a.busy); end
    watch(0, 6, first, count, last);
    checks++; if (count !== 0) begin errors++; $display("FAIL trig_cancel_pulse: got %0d pulses want 0", count); end
  endtask

  task automatic test_cancel_expiry();
    int first, count, last;
    if_a.N = 16'd4; if_a.trigger = 1'b1;
    step();
    if_a.trigger = 1'b0;
    watch(0, 3, first, count, last);
    checks++; if (count !== 0 || if_a.remaining !== 16'd1) begin errors++; $display("FAIL cancel_exp_pre: got count=%0d rem=%0d want 0 1", count, if_a.remaining); end
    if_a.cancel = 1'b1;
    step();
    if_a.cancel = 1'b0;
    checks++; if (if_a.time_out !== 1'b0 || if_a.busy !== 1'b0 || if_a.remaining !== 16'd0) begin errors++; $display("FAIL cancel_exp_edge: got to=%0b busy=%0b rem=%0d want 0 0 0", if_a.time_out, if_a.busy, if_a.remaining); end
    watch(0, 5, first, count, last);
    checks++; if (count !== 0) begin errors++; $display("FAIL cancel_exp_after: got %0d pulses want 0", count); end
  endtask

  task automatic test_retrigger();
    int first, count, last;
    int exp_rem, exp_first;
`ifdef DELAY_TIMER_RETRIGGER_EN
    exp_rem = 6; exp_first = 6;
`else
    exp_rem = 3; exp_first = 3;
`endif
    if_a.N = 16'd6; if_a.periodic = 1'b0; if_a.trigger = 1'b1;
    step();
    if_a.trigger = 1'b0;
    step(); step();
    if_a.trigger = 1'b1;
    step();
    if_a.trigger = 1'b0;
    checks++; if (if_a.remaining !== 16'(exp_rem)) begin errors++; $display("FAIL retrigger_rem: got %0d want %0d", if_a.remaining, exp_rem); end
    watch(0, 12, first, count, last);
    checks++; if (first !== exp_first || count !== 1) begin errors++; $display("FAIL retrigger_pulse: got first=%0d count=%0d want %0d 1", first, count, exp_first); end
  endtask

  task automatic test_back_to_back();
    int first, count, last;
    int exp_first, exp_count;
`ifdef DELAY_TIMER_RETRIGGER_EN
    exp_first = -1; exp_count = 0;
`else
    exp_first = 2; exp_count = 3;
`endif
    if_a.N = 16'd2; if_a.periodic = 1'b0; if_a.trigger = 1'b1;
    step();
    watch(0, 9, first, count, last);
    if_a.trigger = 1'b0;
    checks++; if (first !== exp_first || count !== exp_count) begin errors++; $display("FAIL held_trigger: got first=%0d count=%0d want %0d %0d", first, count, exp_first, exp_count); end
    watch(0, 5, first, count, last);
    checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL held_trigger_idle: got busy=%0b want 0", if_a.busy); end
  endtask

  initial begin
    if_a.trigger = 1'b0; if_a.cancel = 1'b0; if_a.periodic = 1'b0; if_a.N = '0;
    if_b.trigger = 1'b0; if_b.cancel = 1'b0; if_b.periodic = 1'b0; if_b.N = '0;
    if_c.trigger = 1'b0; if_c.cancel = 1'b0; if_c.periodic = 1'b0; if_c.N = '0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_boundaries();
    test_cancel_expiry();
    test_retrigger();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
